// File: rtl/issue_entry_fifo.sv
// issue_entry_fifo: an in-order buffer for decoded scoreboard entries, placed
// between decode and issue. The head entry is held on a valid/ack handshake,
// and the second-oldest entry is shown as a lookahead.
// Optional feature macro: ISSUE_FIFO_BYPASS_EN. When it is defined, a push
// into an empty FIFO appears on the head outputs in the same cycle.
// ariane_pkg is a local stand-in so this file builds on its own. Swap it for
// the real core package when integrating.

package ariane_pkg;
   typedef struct packed {
      logic [63:0] pc;
      logic [2:0]  trans_id;
      logic [3:0]  fu;
      logic [7:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] result;
      logic        valid;
   } scoreboard_entry_t;
endpackage

module issue_entry_fifo #(
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          flush_i,
   input  logic                          debug_req_i,
   input  ariane_pkg::scoreboard_entry_t decoded_instr_i,
   input  logic                          decoded_instr_valid_i,
   input  logic                          is_ctrl_flow_i,
   output logic                          decoded_instr_ack_o,
   output ariane_pkg::scoreboard_entry_t issue_entry_o,
   output logic                          issue_entry_valid_o,
   output logic                          is_ctrl_flow_o,
   input  logic                          issue_instr_ack_i,
   output ariane_pkg::scoreboard_entry_t next_entry_o,
   output logic                          next_entry_valid_o,
   output logic [CNT_W-1:0]              count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

   typedef struct packed {
      ariane_pkg::scoreboard_entry_t sbe;
      logic                          ctrlFlow;
   } slot_t;

   slot_t             mem_q [DEPTH];
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              pushReq;
   logic              bypassTaken;
   logic              doPush;
   logic              doPop;
   logic              headValid;
   logic              bypassShow;
   logic [PTR_W-1:0]  nextPtr;

   // Handshake decisions. The input ack does not depend on the consumer ack,
   // so a full FIFO refuses input even when the head is popped that cycle.
   always_comb begin
      decoded_instr_ack_o = (count_q < DEPTH_C) & ~debug_req_i & ~flush_i;
      pushReq             = decoded_instr_valid_i & decoded_instr_ack_o;
      headValid           = (count_q != '0);
`ifdef ISSUE_FIFO_BYPASS_EN
      bypassShow          = (count_q == '0) & pushReq;
`else
      bypassShow          = 1'b0;
`endif
      bypassTaken         = bypassShow & issue_instr_ack_i;
      doPush              = pushReq & ~bypassTaken;
      doPop               = headValid & issue_instr_ack_i;
      nextPtr             = rdPtr_q + PTR_W'(1);
   end

   // Next-state pointers and occupancy. A flush overrides any push or pop.
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (flush_i) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
      end
   end

   // Storage and pointer registers. Reset clears every slot, so no stale data is visible.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (doPush) mem_q[wrPtr_q] <= '{sbe: decoded_instr_i, ctrlFlow: is_ctrl_flow_i};
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   // Head and lookahead outputs. Each is zeroed while its valid is low.
   always_comb begin
      issue_entry_valid_o = headValid | bypassShow;
      issue_entry_o       = '0;
      is_ctrl_flow_o      = 1'b0;
      if (headValid) begin
         issue_entry_o  = mem_q[rdPtr_q].sbe;
         is_ctrl_flow_o = mem_q[rdPtr_q].ctrlFlow;
      end else if (bypassShow) begin
         issue_entry_o  = decoded_instr_i;
         is_ctrl_flow_o = is_ctrl_flow_i;
      end
      next_entry_valid_o = (count_q >= TWO_C);
      next_entry_o       = next_entry_valid_o ? mem_q[nextPtr].sbe : '0;
      count_o            = count_q;
   end

`ifndef SYNTHESIS
   // Occupancy can never exceed the number of slots.
   assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= DEPTH_C);
`endif

endmodule

// File: tb/tb_issue_entry_fifo.sv
// Directed testbench for issue_entry_fifo. The default build expects registered
// head output. Define ISSUE_FIFO_BYPASS_EN to expect same-cycle bypass instead.

module tb_issue_entry_fifo;

   logic                          clk_i;
   logic                          rst_ni;
   logic                          flush_i;
   logic                          debug_req_i;
   ariane_pkg::scoreboard_entry_t decoded_instr_i;
   logic                          decoded_instr_valid_i;
   logic                          is_ctrl_flow_i;
   logic                          decoded_instr_ack_o;
   ariane_pkg::scoreboard_entry_t issue_entry_o;
   logic                          issue_entry_valid_o;
   logic                          is_ctrl_flow_o;
   logic                          issue_instr_ack_i;
   ariane_pkg::scoreboard_entry_t next_entry_o;
   logic                          next_entry_valid_o;
   logic [2:0]                    count_o;

   int checkCount = 0;
   int passCount  = 0;

   issue_entry_fifo #(.DEPTH(4)) dut (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .flush_i               (flush_i),
      .debug_req_i           (debug_req_i),
      .decoded_instr_i       (decoded_instr_i),
      .decoded_instr_valid_i (decoded_instr_valid_i),
      .is_ctrl_flow_i        (is_ctrl_flow_i),
      .decoded_instr_ack_o   (decoded_instr_ack_o),
      .issue_entry_o         (issue_entry_o),
      .issue_entry_valid_o   (issue_entry_valid_o),
      .is_ctrl_flow_o        (is_ctrl_flow_o),
      .issue_instr_ack_i     (issue_instr_ack_i),
      .next_entry_o          (next_entry_o),
      .next_entry_valid_o    (next_entry_valid_o),
      .count_o               (count_o)
   );

   // Free-running 10 ns clock
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Build an entry whose side fields are derived from the pc, so the whole payload is traceable
   function automatic ariane_pkg::scoreboard_entry_t makeEntry(input logic [63:0] pc);
      ariane_pkg::scoreboard_entry_t e;
      e        = '0;
      e.pc     = pc;
      e.rd     = pc[6:2];
      e.result = ~pc;
      e.valid  = 1'b1;
      return e;
   endfunction

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   // Drive one cycle's worth of inputs; the control-flow flag follows pc bit 2
   task automatic applyStimulus(input logic valid, input logic [63:0] pc, input logic issueAck,
                                input logic flush, input logic debug);
      decoded_instr_valid_i = valid;
      decoded_instr_i       = valid ? makeEntry(pc) : '0;
      is_ctrl_flow_i        = valid & pc[2];
      issue_instr_ack_i     = issueAck;
      flush_i               = flush;
      debug_req_i           = debug;
      #1;
   endtask

   // Move to just after the next rising edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Push a run of consecutive pcs with the consumer stalled
   task automatic fillEntries(input logic [63:0] basePc, input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, basePc + 64'(4 * i), 1'b0, 1'b0, 1'b0);
         tick();
      end
   endtask

   initial begin
      rst_ni = 1'b0;
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_count", 64'(count_o), 64'd0);
      checkOutput("reset_valid", 64'(issue_entry_valid_o), 64'd0);
      checkOutput("reset_next_valid", 64'(next_entry_valid_o), 64'd0);
      checkOutput("reset_head_pc", issue_entry_o.pc, 64'h0);
      checkOutput("reset_ack", 64'(decoded_instr_ack_o), 64'd1);
      #11 rst_ni = 1'b1;

      // Fill to capacity, then drain in order
      fillEntries(64'h80, 4);
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("fill_count", 64'(count_o), 64'd4);
      checkOutput("fill_ack", 64'(decoded_instr_ack_o), 64'd0);
      checkOutput("fill_head_pc", issue_entry_o.pc, 64'h80);
      checkOutput("fill_head_result", issue_entry_o.result, ~64'h80);
      checkOutput("fill_next_valid", 64'(next_entry_valid_o), 64'd1);
      checkOutput("fill_next_pc", next_entry_o.pc, 64'h84);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
         checkOutput("drain_valid", 64'(issue_entry_valid_o), 64'd1);
         checkOutput("drain_pc", issue_entry_o.pc, 64'h80 + 64'(4 * i));
         checkOutput("drain_ctrl", 64'(is_ctrl_flow_o), 64'(i % 2));
         tick();
      end
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("drained_valid", 64'(issue_entry_valid_o), 64'd0);
      checkOutput("drained_count", 64'(count_o), 64'd0);
      checkOutput("drained_head_pc", issue_entry_o.pc, 64'h0);

      // A full FIFO refuses input even while the head is being popped
      fillEntries(64'h80, 4);
      applyStimulus(1'b1, 64'h90, 1'b1, 1'b0, 1'b0);
      checkOutput("full_pop_ack", 64'(decoded_instr_ack_o), 64'd0);
      tick();
      applyStimulus(1'b1, 64'h90, 1'b0, 1'b0, 1'b0);
      checkOutput("full_pop_count", 64'(count_o), 64'd3);
      checkOutput("full_pop_head", issue_entry_o.pc, 64'h84);
      checkOutput("full_pop_ack_back", 64'(decoded_instr_ack_o), 64'd1);
      tick();
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("full_refill_count", 64'(count_o), 64'd4);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
         checkOutput("full_drain_pc", issue_entry_o.pc, 64'h84 + 64'(4 * i));
         tick();
      end

      // Steady state at two entries: ten push/pop pairs wrap both pointers
      fillEntries(64'h100, 2);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 64'h108 + 64'(4 * i), 1'b1, 1'b0, 1'b0);
         checkOutput("wrap_head", issue_entry_o.pc, 64'h100 + 64'(4 * i));
         checkOutput("wrap_next", next_entry_o.pc, 64'h104 + 64'(4 * i));
         checkOutput("wrap_count", 64'(count_o), 64'd2);
         tick();
      end
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("wrap_end_head", issue_entry_o.pc, 64'h128);
      checkOutput("wrap_end_next", next_entry_o.pc, 64'h12C);
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();

      // Flush beats a simultaneous push and pop
      fillEntries(64'h200, 3);
      applyStimulus(1'b1, 64'hA0, 1'b1, 1'b1, 1'b0);
      checkOutput("flush_ack", 64'(decoded_instr_ack_o), 64'd0);
      tick();
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("flush_count", 64'(count_o), 64'd0);
      checkOutput("flush_valid", 64'(issue_entry_valid_o), 64'd0);
      checkOutput("flush_next_valid", 64'(next_entry_valid_o), 64'd0);
      fillEntries(64'h210, 1);
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("post_flush_head", issue_entry_o.pc, 64'h210);
      checkOutput("post_flush_count", 64'(count_o), 64'd1);
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      tick();

      // Debug request blocks input while the contents keep draining
      fillEntries(64'h300, 2);
      applyStimulus(1'b1, 64'h308, 1'b0, 1'b0, 1'b1);
      checkOutput("debug_ack", 64'(decoded_instr_ack_o), 64'd0);
      tick();
      applyStimulus(1'b1, 64'h308, 1'b1, 1'b0, 1'b1);
      checkOutput("debug_count", 64'(count_o), 64'd2);
      checkOutput("debug_head0", issue_entry_o.pc, 64'h300);
      tick();
      applyStimulus(1'b1, 64'h308, 1'b1, 1'b0, 1'b1);
      checkOutput("debug_head1", issue_entry_o.pc, 64'h304);
      tick();
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("debug_drained", 64'(count_o), 64'd0);
      checkOutput("debug_drained_valid", 64'(issue_entry_valid_o), 64'd0);
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("debug_release_ack", 64'(decoded_instr_ack_o), 64'd1);

      // Push into an empty FIFO while the consumer acks
      applyStimulus(1'b1, 64'hB0, 1'b1, 1'b0, 1'b0);
`ifdef ISSUE_FIFO_BYPASS_EN
      checkOutput("bypass_valid", 64'(issue_entry_valid_o), 64'd1);
      checkOutput("bypass_pc", issue_entry_o.pc, 64'hB0);
      tick();
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("bypass_count", 64'(count_o), 64'd0);
`else
      checkOutput("nobypass_valid", 64'(issue_entry_valid_o), 64'd0);
      tick();
      applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("nobypass_count", 64'(count_o), 64'd1);
      checkOutput("nobypass_head", issue_entry_o.pc, 64'hB0);
      checkOutput("nobypass_valid_next", 64'(issue_entry_valid_o), 64'd1);
`endif

      // Asynchronous reset while operating clears everything immediately
      fillEntries(64'h400, 2);
      #2 rst_ni = 1'b0;
      #1;
      checkOutput("async_reset_count", 64'(count_o), 64'd0);
      checkOutput("async_reset_valid", 64'(issue_entry_valid_o), 64'd0);
      rst_ni = 1'b1;
      tick();

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
